// File: rtl/noise_ref_aligner_pkg.sv
// rtl/noise_ref_aligner_pkg.sv - shared ANC datapath widths and delay-line geometry
package noise_ref_aligner_pkg;

  // Sample width shared with the downstream error subtractor.
  localparam int DATA_W          = 16;
  // Reference delay-line depth (power of 2) and its address width.
  localparam int ANC_DELAY_DEPTH = 64;
  localparam int ANC_DELAY_AW    = 6;

endpackage

// File: rtl/noise_ref_aligner_sample_delay_ram.sv
// rtl/noise_ref_aligner_sample_delay_ram.sv - simple dual-port distributed RAM for the reference delay line
module sample_delay_ram
  import noise_ref_aligner_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int D  = ANC_DELAY_DEPTH,
  parameter int AW = ANC_DELAY_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [D];

  // Synchronous write; contents are never reset, stale data is masked upstream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read returns the old word when raddr == waddr (read before write).
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/noise_ref_aligner.sv
// rtl/noise_ref_aligner.sv - pairs primary/reference samples and delays the reference
module noise_ref_aligner
  import noise_ref_aligner_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ANC_DELAY_AW-1:0] delay,
  input  logic [DATA_W-1:0]       pri_in,
  input  logic                    pri_valid,
  input  logic [DATA_W-1:0]       ref_in,
  input  logic                    ref_valid,
  output logic [DATA_W-1:0]       out_pri,
  output logic [DATA_W-1:0]       out_ref,
  output logic                    out_valid,
  output logic                    overrun,
  input  logic                    clear_ovr
);

  localparam logic [ANC_DELAY_AW-1:0] FILL_MAX = ANC_DELAY_AW'(ANC_DELAY_DEPTH - 1);

  logic                    pri_full_q, pri_full_d;
  logic                    ref_full_q, ref_full_d;
  logic [DATA_W-1:0]       pri_slot_q, pri_slot_d;
  logic [DATA_W-1:0]       ref_slot_q, ref_slot_d;
  logic [ANC_DELAY_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ANC_DELAY_AW-1:0] fill_q, fill_d;
  logic [ANC_DELAY_AW-1:0] delay_q, delay_d;
  logic [DATA_W-1:0]       out_pri_q, out_pri_d;
  logic [DATA_W-1:0]       out_ref_q, out_ref_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    pair;
  logic                    ovr_set;
  logic [DATA_W-1:0]       pri_cur, ref_cur, ref_sel, ram_rdata;
  logic [ANC_DELAY_AW-1:0] rd_addr, fill_eff;

  sample_delay_ram u_ram (
    .clk   (clk),
    .we    (pair),
    .waddr (wr_ptr_q),
    .wdata (ref_cur),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // A fresh strobe always wins over the held slot value, so an overwrite pairs with the newest sample.
  assign pri_cur  = pri_valid ? pri_in : pri_slot_q;
  assign ref_cur  = ref_valid ? ref_in : ref_slot_q;
  assign pair     = (pri_valid | pri_full_q) & (ref_valid | ref_full_q);
  assign ovr_set  = (pri_valid & pri_full_q) | (ref_valid & ref_full_q);
  assign rd_addr  = wr_ptr_q - delay;
  // A new delay value restarts warm-up starting with the very pair that carries it.
  assign fill_eff = (delay != delay_q) ? '0 : fill_q;

  // Reference selection: bypass at zero delay, zeros during warm-up, else the delayed sample.
  always_comb begin
    ref_sel = ram_rdata;
    if (delay == '0) begin
      ref_sel = ref_cur;
    end else if (fill_eff < delay) begin
      ref_sel = '0;
    end
  end

  // Next-state for slots, pointers, output registers and the sticky overrun flag.
  always_comb begin
    pri_full_d  = pri_full_q;
    ref_full_d  = ref_full_q;
    pri_slot_d  = pri_slot_q;
    ref_slot_d  = ref_slot_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    delay_d     = delay_q;
    out_pri_d   = out_pri_q;
    out_ref_d   = out_ref_q;
    out_valid_d = pair;
    overrun_d   = ovr_set | (overrun_q & ~clear_ovr);
    if (pair) begin
      pri_full_d = 1'b0;
      ref_full_d = 1'b0;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fill_d     = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + 1'b1;
      delay_d    = delay;
      out_pri_d  = pri_cur;
      out_ref_d  = ref_sel;
    end else begin
      if (pri_valid) begin
        pri_full_d = 1'b1;
        pri_slot_d = pri_in;
      end
      if (ref_valid) begin
        ref_full_d = 1'b1;
        ref_slot_d = ref_in;
      end
    end
  end

  // State registers; reset empties slots and counters but leaves the RAM alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_full_q  <= 1'b0;
      ref_full_q  <= 1'b0;
      pri_slot_q  <= '0;
      ref_slot_q  <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      delay_q     <= '0;
      out_pri_q   <= '0;
      out_ref_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pri_full_q  <= pri_full_d;
      ref_full_q  <= ref_full_d;
      pri_slot_q  <= pri_slot_d;
      ref_slot_q  <= ref_slot_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      delay_q     <= delay_d;
      out_pri_q   <= out_pri_d;
      out_ref_q   <= out_ref_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_pri   = out_pri_q;
  assign out_ref   = out_ref_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
